nav_sequencer: RTL and testbench
================================

# nav_sequencer

Parametrised successor to the single-pass rover controller. It runs the full navigation loop: locate, orientation probe move, locate, orientation calculation, path command calculation, move, locate, then a target check. The loop repeats until the rover is within tolerance or the attempt budget runs out. The block sits in the main FPGA between the ultrasound locator, the orientation and path helpers, and the IR transmitter.

## Interface
- `LOC_W`, 12: location width; `[7:0]` is r, `[LOC_W-1:8]` is theta sector.
- `CMD_W`, 12: move command width; `[7:0]` is distance units, upper bits are turn.
- `MOVE_DELAY_FACTOR`, 27000000: clock cycles per distance unit.
- `ORIENT_STEP`, 12'h005: fixed forward probe command.
- `R_TOL`, 8'd4: radial tolerance for reached.
- `MAX_ATTEMPTS`, 8: loop iterations before failing; must be ≥1.
- `TIMEOUT_CYC`, 2^24: watchdog limit per helper wait (`NAV_TIMEOUT_EN` only).

Ports:
- `clock`, in, 1: system clock.
- `reset`, in, 1: reset, synchronous, active-high. Clock is `clock`.
- `enable`, in, 1: start request, sampled in IDLE.
- `abort`, in, 1: return to IDLE.
- `target_location`, in, `LOC_W`: goal, captured at start.
- `us_start`, out, 1: one-cycle pulse to the locator.
- `us_done`, in, 1: locator done pulse.
- `rover_location`, in, `LOC_W`: valid on `us_done`.
- `orient_start`, out, 1: pulse. `orient_done`, in, 1.
- `path_start`, out, 1: pulse. `path_done`, in, 1. `path_command`, in, `CMD_W`.
- `original_location`, `updated_location`, out, `LOC_W`: registered helper operands.
- `move_command`, out, `CMD_W`: command for the IR transmitter.
- `transmit_ir`, out, 1: one-cycle pulse.
- `reached_target`, out, 1: level, set on success.
- `failed`, out, 1: level, set on budget or timeout exhaustion.
- `busy`, out, 1: high whenever not in IDLE.
- `attempt`, out, 8: current iteration count.
- `state`, out, 4: debug.

## Operation
- States and transitions:
  - IDLE(0) → US1 on `enable`. Captures the target, clears `attempt`, `reached_target` and `failed`, and pulses `us_start`.
  - US1(1) → ORIENT_TX on `us_done`. Latches `original_location`.
  - ORIENT_TX(2) → MOVE_WAIT_O. Sets `move_command = ORIENT_STEP`, pulses `transmit_ir`, loads `timer = MOVE_DELAY_FACTOR*cmd[7:0]`.
  - MOVE_WAIT_O(3) → US2 when `timer == 0`, otherwise decrements. Pulses `us_start` on exit.
  - US2(4) → ORIENT_CALC on `us_done`. Latches `updated_location` and pulses `orient_start`.
  - ORIENT_CALC(5) → PATH_CALC on `orient_done`. Pulses `path_start`.
  - PATH_CALC(6) → MOVE_WAIT on `path_done`. Latches `move_command = path_command`, pulses `transmit_ir`, loads the timer.
  - MOVE_WAIT(7) → US3 when the timer reaches zero. Pulses `us_start`.
  - US3(8) → CHECK on `us_done`. Latches `updated_location`.
  - CHECK(9):
    - If within tolerance → DONE.
    - Else if `attempt+1 == MAX_ATTEMPTS` → FAIL.
    - Else increment `attempt` → US1 with a `us_start` pulse.
  - DONE(A) → IDLE. Sets `reached_target`.
  - FAIL(B) → IDLE. Sets `failed`.
- Reached condition: `|r_rover − r_target| ≤ R_TOL`, computed as 9-bit unsigned difference, and theta fields equal.
- Timer is 34 bits. The product is computed at full width and truncated to 34. A zero-distance command leaves wait on the next cycle.
- Done pulses arriving outside their wait state are ignored.
- `abort` in any non-IDLE state → IDLE next cycle. All pulses go low, the timer is cleared, and `reached_target`/`failed` hold their values.
- If `abort` and `enable` are both high in IDLE, abort wins and the block stays in IDLE.
- `enable` held high re-triggers a new run after DONE or FAIL, one cycle later.

## Timing
- Reset values:
  - `state` = IDLE.
  - All pulses and levels 0.
  - `move_command`, `original_location`, `updated_location`, `attempt` = 0.
  - Timer = 0.
- Start latency: `us_start` is high the cycle after `enable` is sampled.
- Each start pulse is registered and one cycle wide. It is issued on the same edge as the entering transition.
- A done pulse with the matching start is accepted in the cycle after the start pulse at the earliest.
- Move wait lasts `MOVE_DELAY_FACTOR*d + 1` cycles, counted from the `transmit_ir` edge to the `us_start` edge.
- CHECK resolves in one cycle. `reached_target` rises two cycles after `us_done` in US3.

## Configuration
- `NAV_TIMEOUT_EN` defined:
  - A 32-bit watchdog clears on every state entry.
  - In US1/US2/US3/ORIENT_CALC/PATH_CALC, reaching `TIMEOUT_CYC` → FAIL, with `failed = 1`.
- `NAV_TIMEOUT_EN` undefined:
  - No watchdog logic; waits are unbounded.
  - The `TIMEOUT_CYC` parameter is ignored.

## Structure
- Shared package `nav_pkg`:
  - State encoding constants.
  - `ON`/`OFF`.
  - Location field-slice helpers: r at `[7:0]`, theta at `[LOC_W-1:8]`.
  - Default `MOVE_DELAY_FACTOR`.
- One natural sub-module: `move_delay_timer`. It has load, value, and zero-flag outputs, and is used by both move-wait states.

## Test plan
- `MOVE_DELAY_FACTOR=4`, `ORIENT_STEP=5`, `enable` pulse, then:
  - Expect `us_start` next cycle.
  - Expect `transmit_ir` with `move_command = 0x005`.
  - Expect a 21-cycle wait, then a second `us_start`.
- Target `0x310`, final location `0x313` → `reached_target = 1` after one attempt, `attempt = 0`, back to IDLE.
- `MAX_ATTEMPTS=3`, locator always returns `0x150` against target `0x310` → `failed = 1` after the third CHECK, with exactly 9 `us_start` pulses.
- `path_command = 0x100` (zero distance) → US3 `us_start` on the cycle after `transmit_ir`.
- Mid-MOVE_WAIT `abort`, then spurious `us_done` → IDLE next cycle, no pulses, and `us_done` ignored.
- With `NAV_TIMEOUT_EN` and `TIMEOUT_CYC=16`, withhold `orient_done` → FAIL after 16 cycles in ORIENT_CALC, then `failed = 1`.

Source files
------------

// File: rtl/nav_pkg.sv
// Shared types and helpers for the navigation sequencer.
package nav_pkg;

  typedef enum logic [3:0] {
    StIdle       = 4'h0,
    StUs1        = 4'h1,
    StOrientTx   = 4'h2,
    StMoveWaitO  = 4'h3,
    StUs2        = 4'h4,
    StOrientCalc = 4'h5,
    StPathCalc   = 4'h6,
    StMoveWait   = 4'h7,
    StUs3        = 4'h8,
    StCheck      = 4'h9,
    StDone       = 4'hA,
    StFail       = 4'hB
  } nav_state_e;

  localparam logic ON  = 1'b1;
  localparam logic OFF = 1'b0;

  localparam int unsigned DefaultMoveDelayFactor = 27000000;
  localparam int unsigned TimerW                 = 34;
  // Locations are zero-extended to this width before slicing.
  localparam int unsigned LocMaxW                = 32;

  // Radial field of a location.
  function automatic logic [7:0] loc_r(input logic [LocMaxW-1:0] loc);
    return 8'(loc);
  endfunction

  // Theta sector field of a location.
  function automatic logic [LocMaxW-9:0] loc_theta(input logic [LocMaxW-1:0] loc);
    return loc[LocMaxW-1:8];
  endfunction

  // Absolute radial difference taken at 9 bits so it cannot wrap.
  function automatic logic within_tol(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] tol);
    logic [8:0] diff;
    diff = (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
    return diff <= {1'b0, tol};
  endfunction

endpackage

// File: rtl/nav_sequencer_if.sv
// Handshake bundle between the sequencer and its locator/orientation/path/IR helpers.
interface nav_sequencer_if #(
  parameter int unsigned LOC_W = 12,
  parameter int unsigned CMD_W = 12
);
  logic             us_start;
  logic             us_done;
  logic [LOC_W-1:0] rover_location;
  logic             orient_start;
  logic             orient_done;
  logic             path_start;
  logic             path_done;
  logic [CMD_W-1:0] path_command;
  logic [LOC_W-1:0] original_location;
  logic [LOC_W-1:0] updated_location;
  logic [CMD_W-1:0] move_command;
  logic             transmit_ir;

  modport master (
    output us_start, orient_start, path_start, original_location, updated_location,
           move_command, transmit_ir,
    input  us_done, rover_location, orient_done, path_done, path_command
  );

  modport slave (
    input  us_start, orient_start, path_start, original_location, updated_location,
           move_command, transmit_ir,
    output us_done, rover_location, orient_done, path_done, path_command
  );
endinterface

// File: rtl/move_delay_timer.sv
// Down-counter that times a rover move: loads factor * distance, counts to zero.
module move_delay_timer import nav_pkg::*; #(
  parameter int unsigned MOVE_DELAY_FACTOR = DefaultMoveDelayFactor
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic              dec_i,
  input  logic [7:0]        dist_i,
  output logic [TimerW-1:0] value_o,
  output logic              zero_o
);

  logic [TimerW-1:0] timer_q, timer_d;
  logic [39:0]       prod;
  logic              unused_prod_hi;

  // Full-width product, truncated to the timer width.
  assign prod           = 40'(MOVE_DELAY_FACTOR) * 40'(dist_i);
  assign unused_prod_hi = ^prod[39:TimerW];

  // Next count: clear beats load beats decrement.
  always_comb begin
    timer_d = timer_q;
    if (clear_i) begin
      timer_d = '0;
    end else if (load_i) begin
      timer_d = prod[TimerW-1:0];
    end else if (dec_i && (timer_q != '0)) begin
      timer_d = timer_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clock) begin
    if (reset) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  assign value_o = timer_q;
  assign zero_o  = (timer_q == '0);

endmodule

// File: rtl/nav_sequencer.sv
// Navigation loop controller: locate, probe move, locate, orient, path, move, locate, check.
// Optional watchdog on helper waits when NAV_TIMEOUT_EN is defined.
module nav_sequencer import nav_pkg::*; #(
  parameter int unsigned     LOC_W             = 12,
  parameter int unsigned     CMD_W             = 12,
  parameter int unsigned     MOVE_DELAY_FACTOR = DefaultMoveDelayFactor,
  parameter logic [CMD_W-1:0] ORIENT_STEP      = CMD_W'('h005),
  parameter logic [7:0]      R_TOL             = 8'd4,
  parameter int unsigned     MAX_ATTEMPTS      = 8,
  parameter int unsigned     TIMEOUT_CYC       = 32'd16777216
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             abort,
  input  logic [LOC_W-1:0] target_location,
  nav_sequencer_if.master  bus,
  output logic             reached_target,
  output logic             failed,
  output logic             busy,
  output logic [7:0]       attempt,
  output logic [3:0]       state
);

  nav_state_e        state_q, state_d;
  logic [LOC_W-1:0]  target_q, target_d;
  logic [LOC_W-1:0]  orig_q, orig_d;
  logic [LOC_W-1:0]  upd_q, upd_d;
  logic [CMD_W-1:0]  move_cmd_q, move_cmd_d;
  logic              us_start_q, us_start_d;
  logic              orient_start_q, orient_start_d;
  logic              path_start_q, path_start_d;
  logic              transmit_q, transmit_d;
  logic              reached_q, reached_d;
  logic              failed_q, failed_d;
  logic [7:0]        attempt_q, attempt_d;

  logic              tmr_clear, tmr_load, tmr_dec, tmr_zero;
  logic [7:0]        tmr_dist;
  logic [TimerW-1:0] unused_tmr_value;
  logic              timeout, at_target, last_attempt;

  assign at_target = within_tol(loc_r(LocMaxW'(upd_q)), loc_r(LocMaxW'(target_q)), R_TOL) &&
                     (loc_theta(LocMaxW'(upd_q)) == loc_theta(LocMaxW'(target_q)));
  assign last_attempt = (32'(attempt_q) + 32'd1) == MAX_ATTEMPTS;

  move_delay_timer #(
    .MOVE_DELAY_FACTOR(MOVE_DELAY_FACTOR)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clear_i (tmr_clear),
    .load_i  (tmr_load),
    .dec_i   (tmr_dec),
    .dist_i  (tmr_dist),
    .value_o (unused_tmr_value),
    .zero_o  (tmr_zero)
  );

  // Next state, registered pulses and operand latches.
  always_comb begin
    state_d        = state_q;
    target_d       = target_q;
    orig_d         = orig_q;
    upd_d          = upd_q;
    move_cmd_d     = move_cmd_q;
    attempt_d      = attempt_q;
    reached_d      = reached_q;
    failed_d       = failed_q;
    us_start_d     = OFF;
    orient_start_d = OFF;
    path_start_d   = OFF;
    transmit_d     = OFF;
    tmr_clear      = OFF;
    tmr_load       = OFF;
    tmr_dec        = OFF;
    tmr_dist       = 8'd0;

    if (abort && (state_q != StIdle)) begin
      state_d   = StIdle;
      tmr_clear = ON;
    end else begin
      case (state_q)
        StIdle: begin
          if (enable && !abort) begin
            target_d   = target_location;
            attempt_d  = 8'd0;
            reached_d  = OFF;
            failed_d   = OFF;
            us_start_d = ON;
            state_d    = StUs1;
          end
        end
        // A done in the same cycle as its start pulse is not accepted.
        StUs1: begin
          if (bus.us_done && !us_start_q) begin
            orig_d  = bus.rover_location;
            state_d = StOrientTx;
          end else if (timeout) begin
            failed_d = ON;
            state_d  = StFail;
          end
        end
        StOrientTx: begin
          move_cmd_d = ORIENT_STEP;
          transmit_d = ON;
          tmr_load   = ON;
          tmr_dist   = ORIENT_STEP[7:0];
          state_d    = StMoveWaitO;
        end
        StMoveWaitO: begin
          if (tmr_zero) begin
            us_start_d = ON;
            state_d    = StUs2;
          end else begin
            tmr_dec = ON;
          end
        end
        StUs2: begin
          if (bus.us_done && !us_start_q) begin
            upd_d          = bus.rover_location;
            orient_start_d = ON;
            state_d        = StOrientCalc;
          end else if (timeout) begin
            failed_d = ON;
            state_d  = StFail;
          end
        end
        StOrientCalc: begin
          if (bus.orient_done && !orient_start_q) begin
            path_start_d = ON;
            state_d      = StPathCalc;
          end else if (timeout) begin
            failed_d = ON;
            state_d  = StFail;
          end
        end
        StPathCalc: begin
          if (bus.path_done && !path_start_q) begin
            move_cmd_d = bus.path_command;
            transmit_d = ON;
            tmr_load   = ON;
            tmr_dist   = bus.path_command[7:0];
            state_d    = StMoveWait;
          end else if (timeout) begin
            failed_d = ON;
            state_d  = StFail;
          end
        end
        StMoveWait: begin
          if (tmr_zero) begin
            us_start_d = ON;
            state_d    = StUs3;
          end else begin
            tmr_dec = ON;
          end
        end
        StUs3: begin
          if (bus.us_done && !us_start_q) begin
            upd_d   = bus.rover_location;
            state_d = StCheck;
          end else if (timeout) begin
            failed_d = ON;
            state_d  = StFail;
          end
        end
        StCheck: begin
          if (at_target) begin
            reached_d = ON;
            state_d   = StDone;
          end else if (last_attempt) begin
            failed_d = ON;
            state_d  = StFail;
          end else begin
            attempt_d  = attempt_q + 8'd1;
            us_start_d = ON;
            state_d    = StUs1;
          end
        end
        StDone:  state_d = StIdle;
        StFail:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Sequencer state and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= StIdle;
      target_q       <= '0;
      orig_q         <= '0;
      upd_q          <= '0;
      move_cmd_q     <= '0;
      attempt_q      <= 8'd0;
      reached_q      <= OFF;
      failed_q       <= OFF;
      us_start_q     <= OFF;
      orient_start_q <= OFF;
      path_start_q   <= OFF;
      transmit_q     <= OFF;
    end else begin
      state_q        <= state_d;
      target_q       <= target_d;
      orig_q         <= orig_d;
      upd_q          <= upd_d;
      move_cmd_q     <= move_cmd_d;
      attempt_q      <= attempt_d;
      reached_q      <= reached_d;
      failed_q       <= failed_d;
      us_start_q     <= us_start_d;
      orient_start_q <= orient_start_d;
      path_start_q   <= path_start_d;
      transmit_q     <= transmit_d;
    end
  end

`ifdef NAV_TIMEOUT_EN
  logic [31:0] wdog_q, wdog_d;

  assign timeout = (wdog_q + 32'd1) >= TIMEOUT_CYC;

  // Watchdog restarts on every state change.
  always_comb begin
    wdog_d = (state_d != state_q) ? 32'd0 : wdog_q + 32'd1;
  end

  // Watchdog register.
  always_ff @(posedge clock) begin
    if (reset) begin
      wdog_q <= 32'd0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  logic [31:0] unused_timeout_cyc;

  assign timeout            = OFF;
  assign unused_timeout_cyc = TIMEOUT_CYC;
`endif

  assign bus.us_start          = us_start_q;
  assign bus.orient_start      = orient_start_q;
  assign bus.path_start        = path_start_q;
  assign bus.transmit_ir       = transmit_q;
  assign bus.move_command      = move_cmd_q;
  assign bus.original_location = orig_q;
  assign bus.updated_location  = upd_q;
  assign reached_target        = reached_q;
  assign failed                = failed_q;
  assign attempt               = attempt_q;
  assign busy                  = (state_q != StIdle);
  assign state                 = state_q;

endmodule

// File: tb/tb_nav_sequencer.sv
// Directed bench for nav_sequencer: vector table of single passes plus corner sequences.
module tb_nav_sequencer;

  localparam int unsigned TbFactor  = 4;
  localparam int unsigned TbMaxAtt  = 3;
  localparam int unsigned TbTimeout = 16;
  localparam int          Budget    = 3000;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        abort;
  logic [11:0] target_location;
  logic        reached_target;
  logic        failed;
  logic        busy;
  logic [7:0]  attempt;
  logic [3:0]  state;

  int n_cmp  = 0;
  int n_fail = 0;
  int us_count = 0;

  nav_sequencer_if #(.LOC_W(12), .CMD_W(12)) bus ();

  nav_sequencer #(
    .LOC_W             (12),
    .CMD_W             (12),
    .MOVE_DELAY_FACTOR (TbFactor),
    .ORIENT_STEP       (12'h005),
    .R_TOL             (8'd4),
    .MAX_ATTEMPTS      (TbMaxAtt),
    .TIMEOUT_CYC       (TbTimeout)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .enable          (enable),
    .abort           (abort),
    .target_location (target_location),
    .bus             (bus),
    .reached_target  (reached_target),
    .failed          (failed),
    .busy            (busy),
    .attempt         (attempt),
    .state           (state)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (bus.us_start) us_count <= us_count + 1;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit: simulation still running, required finish");
    $fatal(1, "time limit");
  end

  typedef struct {
    logic [11:0] target;
    logic [11:0] loc1;
    logic [11:0] loc2;
    logic [11:0] loc3;
    logic [11:0] pcmd;
    logic        exp_reached;
    int          exp_wait;
  } vec_t;

  vec_t vecs[9];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic sel(input int which);
    case (which)
      0:       return bus.us_start;
      1:       return bus.orient_start;
      2:       return bus.path_start;
      default: return bus.transmit_ir;
    endcase
  endfunction

  // Steps until the selected pulse is high; returns the number of edges taken.
  task automatic wait_pulse(input int which, input string name, output int cycles);
    int  n = 0;
    logic hit;
    hit = sel(which);
    while (!hit && n < Budget) begin
      step();
      n++;
      hit = sel(which);
    end
    if (!hit) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_%s: no pulse after %0d cycles, required a pulse", name, n);
    end
    cycles = n;
  endtask

  task automatic give_us(input logic [11:0] loc);
    step();
    bus.us_done        = 1'b1;
    bus.rover_location = loc;
    step();
    bus.us_done = 1'b0;
  endtask

  task automatic give_orient();
    step();
    bus.orient_done = 1'b1;
    step();
    bus.orient_done = 1'b0;
  endtask

  task automatic give_path(input logic [11:0] cmd);
    step();
    bus.path_command = cmd;
    bus.path_done    = 1'b1;
    step();
    bus.path_done = 1'b0;
  endtask

  task automatic start(input logic [11:0] tgt);
    target_location = tgt;
    enable          = 1'b1;
    step();
    enable = 1'b0;
    check("start_us_start", 32'(bus.us_start), 32'd1);
    check("start_state", 32'(state), 32'h1);
  endtask

  // One loop pass from the US1 start pulse up to the CHECK state.
  task automatic do_pass(input logic [11:0] l1, input logic [11:0] l2, input logic [11:0] pc,
                         input logic [11:0] l3, output int move_cycles);
    int c;
    give_us(l1);
    wait_pulse(3, "probe_tx", c);
    check("probe_move_command", 32'(bus.move_command), 32'h005);
    wait_pulse(0, "us2_start", c);
    check("probe_wait_cycles", 32'(c), 32'(TbFactor * 5 + 1));
    give_us(l2);
    wait_pulse(1, "orient_start", c);
    give_orient();
    wait_pulse(2, "path_start", c);
    give_path(pc);
    wait_pulse(3, "move_tx", c);
    check("move_command", 32'(bus.move_command), 32'(pc));
    wait_pulse(0, "us3_start", move_cycles);
    give_us(l3);
  endtask

  initial begin
    int mc;
    int base;
    int cnt;

    vecs[0] = '{12'h310, 12'h120, 12'h125, 12'h313, 12'h105, 1'b1, 21};
    vecs[1] = '{12'h310, 12'h120, 12'h125, 12'h314, 12'h100, 1'b1, 1};
    vecs[2] = '{12'h310, 12'h120, 12'h125, 12'h315, 12'h002, 1'b0, 9};
    vecs[3] = '{12'h310, 12'h120, 12'h125, 12'h30C, 12'h201, 1'b1, 5};
    vecs[4] = '{12'h310, 12'h120, 12'h125, 12'h30B, 12'h000, 1'b0, 1};
    vecs[5] = '{12'h310, 12'h120, 12'h125, 12'h410, 12'h103, 1'b0, 13};
    vecs[6] = '{12'h0FE, 12'h120, 12'h125, 12'h002, 12'h101, 1'b0, 5};
    vecs[7] = '{12'h002, 12'h120, 12'h125, 12'h0FF, 12'h100, 1'b0, 1};
    vecs[8] = '{12'hF00, 12'h120, 12'h125, 12'hF03, 12'hA0A, 1'b1, 41};

    reset              = 1'b1;
    enable             = 1'b0;
    abort              = 1'b0;
    target_location    = 12'h000;
    bus.us_done        = 1'b0;
    bus.rover_location = 12'h000;
    bus.orient_done    = 1'b0;
    bus.path_done      = 1'b0;
    bus.path_command   = 12'h000;
    repeat (3) step();
    check("rst_state", 32'(state), 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_attempt", 32'(attempt), 32'd0);
    check("rst_move_command", 32'(bus.move_command), 32'd0);
    check("rst_original", 32'(bus.original_location), 32'd0);
    check("rst_updated", 32'(bus.updated_location), 32'd0);
    check("rst_pulses", {28'd0, bus.us_start, bus.orient_start, bus.path_start,
                         bus.transmit_ir}, 32'd0);
    check("rst_levels", {30'd0, reached_target, failed}, 32'd0);
    reset = 1'b0;
    step();

    // Single-pass vectors: reached -> DONE, otherwise back to US1 then aborted.
    for (int i = 0; i < 9; i++) begin
      start(vecs[i].target);
      do_pass(vecs[i].loc1, vecs[i].loc2, vecs[i].pcmd, vecs[i].loc3, mc);
      check($sformatf("v%0d_move_wait", i), 32'(mc), 32'(vecs[i].exp_wait));
      check($sformatf("v%0d_original", i), 32'(bus.original_location), 32'(vecs[i].loc1));
      check($sformatf("v%0d_updated", i), 32'(bus.updated_location), 32'(vecs[i].loc3));
      check($sformatf("v%0d_check_state", i), 32'(state), 32'h9);
      check($sformatf("v%0d_reached_early", i), 32'(reached_target), 32'd0);
      step();
      check($sformatf("v%0d_reached", i), 32'(reached_target), 32'(vecs[i].exp_reached));
      check($sformatf("v%0d_post_state", i), 32'(state), vecs[i].exp_reached ? 32'hA : 32'h1);
      check($sformatf("v%0d_attempt", i), 32'(attempt), vecs[i].exp_reached ? 32'd0 : 32'd1);
      if (vecs[i].exp_reached) begin
        step();
      end else begin
        abort = 1'b1;
        step();
        abort = 1'b0;
      end
      check($sformatf("v%0d_idle", i), 32'(state), 32'h0);
    end

    // Enable held across DONE re-triggers one cycle after returning to IDLE.
    start(12'h310);
    do_pass(12'h120, 12'h125, 12'h101, 12'h313, mc);
    step();
    check("rt_done_state", 32'(state), 32'hA);
    enable = 1'b1;
    step();
    check("rt_idle_state", 32'(state), 32'h0);
    check("rt_reached_held", 32'(reached_target), 32'd1);
    step();
    enable = 1'b0;
    check("rt_restart_state", 32'(state), 32'h1);
    check("rt_restart_us", 32'(bus.us_start), 32'd1);
    check("rt_reached_clr", 32'(reached_target), 32'd0);
    abort = 1'b1;
    step();
    abort = 1'b0;

    // Budget exhaustion: three misses, nine locator starts, then FAIL.
    base = us_count;
    start(12'h310);
    do_pass(12'h150, 12'h150, 12'h101, 12'h150, mc);
    step();
    check("bf_attempt1", 32'(attempt), 32'd1);
    check("bf_us1_pulse1", 32'(bus.us_start), 32'd1);
    do_pass(12'h150, 12'h150, 12'h101, 12'h150, mc);
    step();
    check("bf_attempt2", 32'(attempt), 32'd2);
    do_pass(12'h150, 12'h150, 12'h101, 12'h150, mc);
    step();
    check("bf_fail_state", 32'(state), 32'hB);
    check("bf_failed", 32'(failed), 32'd1);
    check("bf_reached", 32'(reached_target), 32'd0);
    check("bf_us_count", 32'(us_count - base), 32'd9);
    step();
    check("bf_idle", 32'(state), 32'h0);
    check("bf_failed_held", 32'(failed), 32'd1);
    check("bf_busy", 32'(busy), 32'd0);

    // Abort mid probe wait, then a spurious locator done is ignored.
    start(12'h310);
    give_us(12'h120);
    wait_pulse(3, "ab_tx", cnt);
    repeat (5) step();
    check("ab_wait_state", 32'(state), 32'h3);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("ab_state", 32'(state), 32'h0);
    check("ab_busy", 32'(busy), 32'd0);
    base = us_count;
    bus.us_done        = 1'b1;
    bus.rover_location = 12'h777;
    repeat (4) step();
    bus.us_done = 1'b0;
    check("ab_still_idle", 32'(state), 32'h0);
    check("ab_no_pulses", 32'(us_count - base) + 32'(bus.transmit_ir) + 32'(bus.orient_start),
          32'd0);
    check("ab_original_kept", 32'(bus.original_location), 32'h120);
    // Fresh run after abort gets a full-length probe wait.
    start(12'h310);
    give_us(12'h120);
    wait_pulse(3, "ab2_tx", cnt);
    wait_pulse(0, "ab2_us2", cnt);
    check("ab2_wait_cycles", 32'(cnt), 32'(TbFactor * 5 + 1));
    abort = 1'b1;
    step();
    abort = 1'b0;

    // Abort wins over enable in IDLE.
    abort  = 1'b1;
    enable = 1'b1;
    step();
    abort  = 1'b0;
    enable = 1'b0;
    check("ae_state", 32'(state), 32'h0);
    check("ae_us_start", 32'(bus.us_start), 32'd0);

`ifdef NAV_TIMEOUT_EN
    // Withheld orient_done trips the watchdog after TIMEOUT_CYC cycles.
    start(12'h310);
    give_us(12'h120);
    wait_pulse(3, "to_tx", cnt);
    wait_pulse(0, "to_us2", cnt);
    give_us(12'h125);
    cnt = 0;
    while (state == 4'h5 && cnt < 100) begin
      step();
      cnt++;
    end
    check("to_cycles", 32'(cnt), 32'(TbTimeout));
    check("to_state", 32'(state), 32'hB);
    check("to_failed", 32'(failed), 32'd1);
    step();
    check("to_idle", 32'(state), 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
